// File: rtl/mem_read_port.sv
// Single-outstanding memory read port: issues one read strobe, waits a bounded
// number of cycles for the response, and holds the captured word for the bus.
module mem_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read_req,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] BusMuxIn,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPTURE} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                state = IDLE;
    state_t                state_next;
    logic [7:0]            count = '0;
    logic [7:0]            count_next;
    logic [ADDR_WIDTH-1:0] addr_q = '0;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  rd_q = 1'b0;
    logic                  rd_next;
    logic [DATA_WIDTH-1:0] data_q = '0;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  busy_q = 1'b0;
    logic                  busy_next;
    logic                  done_q = 1'b0;
    logic                  done_next;
    logic                  err_q = 1'b0;
    logic                  err_next;
    logic                  expired;

    assign expired = (count == TIMEOUT_CNT);

    // State and all outputs are registered together; clear wins over everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            count  <= '0;
            addr_q <= '0;
            rd_q   <= 1'b0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            addr_q <= addr_next;
            rd_q   <= rd_next;
            data_q <= data_next;
            busy_q <= busy_next;
            done_q <= done_next;
            err_q  <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (read_req) state_next = REQ;
            REQ:     state_next = WAIT;
            WAIT: begin
                if (mem_ready)    state_next = CAPTURE;
                else if (expired) state_next = IDLE;
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; a ready on the expiry cycle still captures.
    always_comb begin
        count_next = count;
        addr_next  = addr_q;
        rd_next    = 1'b0;
        data_next  = data_q;
        busy_next  = busy_q;
        done_next  = 1'b0;
        err_next   = err_q;
        case (state)
            IDLE: begin
                if (read_req) begin
                    addr_next = addr_in;
                    rd_next   = 1'b1;
                    busy_next = 1'b1;
                    err_next  = 1'b0;
                end
            end
            REQ: count_next = '0;
            WAIT: begin
                if (mem_ready) begin
                    data_next = mem_rdata;
                    done_next = 1'b1;
                end else if (expired) begin
                    err_next  = 1'b1;
                    busy_next = 1'b0;
                end else begin
                    count_next = count + 8'd1;
                end
            end
            CAPTURE: busy_next = 1'b0;
            default: busy_next = 1'b0;
        endcase
    end

    assign mem_addr    = addr_q;
    assign mem_rd      = rd_q;
    assign BusMuxIn    = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_read_port.sv
// Bench for mem_read_port: directed scenarios plus random traffic, all checked
// against a cycle-timeline reference model of the read protocol.
module tb_mem_read_port;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          clear;
    logic          read_req;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic [DW-1:0] BusMuxIn;
    logic          busy;
    logic          done;
    logic          timeout_err;

    always #5 clock = ~clock;

    mem_read_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .clear      (clear),
        .read_req   (read_req),
        .addr_in    (addr_in),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .BusMuxIn   (BusMuxIn),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: a transaction is described by the cycle it was accepted
    // (t_acc) and the cycle its done pulse is due (t_done).
    int            cyc    = 0;
    int            t_acc  = -100;
    int            t_done = -100;
    bit            m_wait = 1'b0;
    bit            m_fin  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            m_err  = 1'b0;

    task automatic step(input bit c, input bit r, input logic [AW-1:0] a,
                        input bit y, input logic [DW-1:0] d);
        clear     = c;
        read_req  = r;
        addr_in   = a;
        mem_ready = y;
        mem_rdata = d;
        @(posedge clock);
        if (c) begin
            m_wait = 1'b0; m_fin = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
            t_acc = -100; t_done = -100;
        end else if (m_fin) begin
            if (cyc == t_done) m_fin = 1'b0;
        end else if (m_wait) begin
            if (cyc >= t_acc + 2) begin
                if (y) begin
                    m_data = d; t_done = cyc + 1; m_wait = 1'b0; m_fin = 1'b1;
                end else if (cyc == t_acc + 2 + TO) begin
                    m_err = 1'b1; m_wait = 1'b0;
                end
            end
        end else if (r) begin
            t_acc = cyc; m_wait = 1'b1; m_addr = a; m_err = 1'b0;
        end
        cyc++;
        #1;
        check_eq("busy",        64'(busy),        64'(m_wait || m_fin));
        check_eq("mem_rd",      64'(mem_rd),      64'(cyc == t_acc + 1));
        check_eq("done",        64'(done),        64'(cyc == t_done));
        check_eq("mem_addr",    64'(mem_addr),    64'(m_addr));
        check_eq("BusMuxIn",    64'(BusMuxIn),    64'(m_data));
        check_eq("timeout_err", 64'(timeout_err), 64'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, $urandom);
    endtask

    int pct;

    initial begin
        clear = 1'b0; read_req = 1'b0; addr_in = '0; mem_ready = 1'b0; mem_rdata = '0;
        #1;
        check_eq("powerup_busy", 64'(busy), 64'(0));
        check_eq("powerup_data", 64'(BusMuxIn), 64'(0));
        check_eq("powerup_err",  64'(timeout_err), 64'(0));

        step(1'b1, 1'b0, '0, 1'b0, '0);
        idle(1);

        // Basic read
        step(1'b0, 1'b1, 9'h005, 1'b0, $urandom);
        idle(1);
        step(1'b0, 1'b0, '0, 1'b1, 32'hDEADBEEF);
        check_eq("basic_data", 64'(BusMuxIn), 64'h0000_0000_DEAD_BEEF);
        check_eq("basic_done", 64'(done), 64'(1));
        check_eq("basic_addr", 64'(mem_addr), 64'h005);
        idle(1);
        check_eq("basic_idle", 64'(busy), 64'(0));

        // Slow memory
        step(1'b0, 1'b1, 9'h100, 1'b0, $urandom);
        idle(9);
        check_eq("slow_busy", 64'(busy), 64'(1));
        step(1'b0, 1'b0, '0, 1'b1, 32'h12345678);
        check_eq("slow_done", 64'(done), 64'(1));
        check_eq("slow_data", 64'(BusMuxIn), 64'h1234_5678);
        idle(1);

        // Timeout, then a new request clears the flag
        step(1'b0, 1'b1, 9'h0F0, 1'b0, $urandom);
        idle(20);
        check_eq("to_err",  64'(timeout_err), 64'(1));
        check_eq("to_busy", 64'(busy), 64'(0));
        check_eq("to_data", 64'(BusMuxIn), 64'h1234_5678);
        step(1'b0, 1'b1, 9'h011, 1'b0, $urandom);
        check_eq("to_cleared", 64'(timeout_err), 64'(0));
        idle(1);
        step(1'b0, 1'b0, '0, 1'b1, 32'hA5A5A5A5);
        idle(2);

        // Request during WAIT is ignored
        step(1'b0, 1'b1, 9'h0AA, 1'b0, $urandom);
        idle(1);
        step(1'b0, 1'b1, 9'h1FF, 1'b0, $urandom);
        check_eq("ign_addr", 64'(mem_addr), 64'h0AA);
        step(1'b0, 1'b0, '0, 1'b1, 32'h00000055);
        idle(3);

        // Clear mid-transaction, late ready ignored
        step(1'b0, 1'b1, 9'h033, 1'b0, $urandom);
        idle(2);
        step(1'b1, 1'b0, '0, 1'b0, $urandom);
        step(1'b0, 1'b0, '0, 1'b1, 32'hCAFEF00D);
        check_eq("clr_data", 64'(BusMuxIn), 64'(0));
        check_eq("clr_done", 64'(done), 64'(0));
        check_eq("clr_addr", 64'(mem_addr), 64'(0));

        // Ready on the exact expiry cycle still captures
        step(1'b0, 1'b1, 9'h077, 1'b0, $urandom);
        idle(1 + TO);
        step(1'b0, 1'b0, '0, 1'b1, 32'hB00DB00D);
        check_eq("edge_done", 64'(done), 64'(1));
        check_eq("edge_err",  64'(timeout_err), 64'(0));
        check_eq("edge_data", 64'(BusMuxIn), 64'h0000_0000_B00D_B00D);
        idle(2);

        // Ready one cycle too late is ignored
        step(1'b0, 1'b1, 9'h078, 1'b0, $urandom);
        idle(2 + TO);
        step(1'b0, 1'b0, '0, 1'b1, 32'h0BADF00D);
        check_eq("late_err",  64'(timeout_err), 64'(1));
        check_eq("late_data", 64'(BusMuxIn), 64'h0000_0000_B00D_B00D);
        idle(2);

        pct = 50;
        for (int i = 0; i < 2400; i++) begin
            if (i % 200 == 0) begin
                case ((i / 200) % 3)
                    0:       pct = 50;
                    1:       pct = 10;
                    default: pct = 3;
                endcase
            end
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, AW'($urandom),
                 $urandom_range(0, 99) < pct, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
